wbu: RTL

- Writeback stage of the single-issue RV32 NPC core. Sits directly upstream of the register file and drives its write port (rd, wen, wdata).
- Accepts completed instructions from EXU/LSU over a valid/ready handshake and holds each one in a one-entry stage register.
- Sign/zero-extends load data, forwards the pending write to decode, keeps a per-register outstanding-write scoreboard, and counts retired instructions.

---
 rtl/npc_pkg.sv | 14 +
 rtl/wbu_scoreboard.sv | 66 ++++++
 rtl/wbu.sv | 114 +++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared NPC core definitions: datapath width, register-address width and
// the RV32 load funct3 encodings used by the writeback stage.
package npc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/wbu_scoreboard.sv
// Per-register outstanding-write scoreboard.
// Ports: clk, rst (async, active-low); iss_valid/iss_rd count up a register,
// ret_wen/ret_rd count one down on writeback; busy flags each register with
// a nonzero count; sb_err is a sticky overflow/underflow flag.
module wbu_scoreboard
    import npc_pkg::*;
#(
    parameter int unsigned SB_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_valid,
    input  logic [REG_W-1:0] iss_rd,
    input  logic             ret_wen,
    input  logic [REG_W-1:0] ret_rd,
    output logic [31:0]      busy,
    output logic             sb_err
);

    localparam logic [SB_W-1:0] CNT_MAX = '1;

    logic [SB_W-1:0] cnt_q [1:31];
    logic [SB_W-1:0] cnt_d [1:31];
    logic [31:1]     inc_v;
    logic [31:1]     dec_v;
    logic            err_evt;

    // Next counter values; x0 is never tracked so the loop starts at 1.
    always_comb begin
        err_evt = 1'b0;
        inc_v   = '0;
        dec_v   = '0;
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            inc_v[i] = iss_valid && (iss_rd == REG_W'(i));
            dec_v[i] = ret_wen && (ret_rd == REG_W'(i));
            if (inc_v[i] && !dec_v[i]) begin
                if (cnt_q[i] == CNT_MAX) err_evt = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_v[i] && !inc_v[i]) begin
                if (cnt_q[i] == '0) err_evt = 1'b1;
                else                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Busy vector; bit 0 stays clear.
    always_comb begin
        busy = '0;
        for (int i = 1; i < 32; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    // Counter and sticky error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) cnt_q[i] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
            if (err_evt) sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/wbu.sv
// Writeback stage: one-entry stage register between EXU/LSU and the
// register file write port.
// Ports: clk, rst (async, active-low); in_* valid/ready upstream handshake;
// hold stalls retirement; iss_valid/iss_rd feed the scoreboard; rf_* drive
// the register file; fwd_* expose the pending write for bypass; busy and
// sb_err come from the scoreboard; retire/instret count retirements.
module wbu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SB_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [npc_pkg::REG_W-1:0] in_rd,
    input  logic                      in_wen,
    input  logic                      in_is_load,
    input  logic [2:0]                in_funct3,
    input  logic [1:0]                in_addr_lo,
    input  logic [XLEN-1:0]           in_result,
    input  logic                      hold,
    input  logic                      iss_valid,
    input  logic [npc_pkg::REG_W-1:0] iss_rd,
    output logic                      rf_wen,
    output logic [npc_pkg::REG_W-1:0] rf_rd,
    output logic [XLEN-1:0]           rf_wdata,
    output logic                      fwd_valid,
    output logic [npc_pkg::REG_W-1:0] fwd_rd,
    output logic [XLEN-1:0]           fwd_data,
    output logic [31:0]               busy,
    output logic                      retire,
    output logic [63:0]               instret,
    output logic                      sb_err
);

    import npc_pkg::*;

    // Select and extend the addressed byte/halfword of a raw load word.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                     input logic [1:0]      lo,
                                                     input logic [XLEN-1:0] word);
        logic [XLEN-1:0] bsh;
        logic [XLEN-1:0] hsh;
        logic [XLEN-1:0] res;
        bsh = word >> {lo, 3'b000};
        hsh = word >> {lo[1], 4'b0000};
        case (f3)
            LB:      res = {{(XLEN-8){bsh[7]}}, bsh[7:0]};
            LBU:     res = {{(XLEN-8){1'b0}}, bsh[7:0]};
            LH:      res = {{(XLEN-16){hsh[15]}}, hsh[15:0]};
            LHU:     res = {{(XLEN-16){1'b0}}, hsh[15:0]};
            LW:      res = word;
            default: res = word;
        endcase
        return res;
    endfunction

    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             wb_wen;
    logic [XLEN-1:0]  wb_data;
    logic             accept;
    logic             wr_pending;

    assign in_ready   = !wb_valid || !hold;
    assign accept     = in_valid && in_ready;
    assign retire     = wb_valid && !hold;
    assign wr_pending = wb_valid && wb_wen && (wb_rd != '0);

    assign rf_wen    = wr_pending && !hold;
    assign rf_rd     = wb_rd;
    assign rf_wdata  = wb_data;
    assign fwd_valid = wr_pending;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;

    // Stage register: a new entry may replace a retiring one on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_wen   <= 1'b0;
            wb_data  <= '0;
        end else if (accept) begin
            wb_valid <= 1'b1;
            wb_rd    <= in_rd;
            wb_wen   <= in_wen;
            wb_data  <= in_is_load ? load_extract(in_funct3, in_addr_lo, in_result)
                                   : in_result;
        end else if (retire) begin
            wb_valid <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        instret <= '0;
        else if (retire) instret <= instret + 64'd1;
    end

    wbu_scoreboard #(
        .SB_W (SB_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .ret_wen   (rf_wen),
        .ret_rd    (wb_rd),
        .busy      (busy),
        .sb_err    (sb_err)
    );

endmodule
